// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell handles a single bit per cycle, LSB first.
// The result is diff = a - b - bin (mod 2^WIDTH), with the borrow reported on bout.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic w_x, w_y, w_d, w_br_next, w_last;

  // The single full-subtractor cell, reused for every bit position
  assign w_x       = r_a[0];
  assign w_y       = r_b[0];
  assign w_d       = w_x ^ w_y ^ r_br;
  assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // busy/done are registered from the next state, so they line up exactly with RUN/DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= (w_next == S_RUN);
      done    <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
          if (w_last) begin
            diff <= {w_d, r_res[WIDTH-1:1]};
            bout <= w_br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Randomised and directed bench for bit_serial_subtractor, comparing against an arithmetic reference.
// Covers WIDTH=8 and an exhaustive sweep on a second instance with WIDTH=2.
module tb_bit_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, bin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic       start2 = 1'b0, bin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, bout2;
  logic [1:0] diff2;

  int pass = 0, total = 0;

  always #5 clk = ~clk;

  bit_serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout));

  bit_serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2));

  // Reference: plain integer subtraction, wrapped modulo 2^w; the borrow is the sign of the result
  function automatic int ref_diff(input int w, input int x, input int y, input int br);
    int m, d;
    m = 1 << w;
    d = x - y - br;
    return (d + m) % m;
  endfunction

  function automatic logic ref_bout(input int x, input int y, input int br);
    return (x < y + br);
  endfunction

  // Starts one WIDTH=8 operation and scrambles the inputs while it runs
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                     output int nbusy, output int lat, output int nhold_err, output logic both);
    logic [7:0] prev_d;
    logic       prev_b;
    @(negedge clk);
    prev_d = diff; prev_b = bout;
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1; nbusy = 0; nhold_err = 0; both = 1'b0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (busy && done) both = 1'b1;
      if (diff !== prev_d || bout !== prev_b) nhold_err++;
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); bin = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    if (busy && done) both = 1'b1;
  endtask

  task automatic check_op8(input string nm, input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
    int nbusy, lat, nh;
    logic both;
    logic [7:0] ed;
    logic eb;
    op8(ia, ib, ibin, nbusy, lat, nh, both);
    ed = 8'(ref_diff(8, ia, ib, ibin));
    eb = ref_bout(ia, ib, ibin);
    total++;
    if (lat !== 9) $display("FAIL %s latency got %0d want 9", nm, lat); else pass++;
    total++;
    if (nbusy !== 8 || both) $display("FAIL %s busy got %0d cycles overlap=%0b want 8/0", nm, nbusy, both); else pass++;
    total++;
    if (diff !== ed || bout !== eb) $display("FAIL %s result got %h/%b want %h/%b", nm, diff, bout, ed, eb); else pass++;
    total++;
    if (nh !== 0) $display("FAIL %s outputs changed before done %0d times want 0", nm, nh); else pass++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s after done busy/done got %b/%b want 0/0", nm, busy, done); else pass++;
    total++;
    if (diff !== ed || bout !== eb) $display("FAIL %s hold got %h/%b want %h/%b", nm, diff, bout, ed, eb); else pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset busy/done got %b/%b want 0/0", busy, done); else pass++;
    total++;
    if (diff !== 8'h00 || bout !== 1'b0) $display("FAIL reset diff/bout got %h/%b want 00/0", diff, bout); else pass++;
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL reset start_discard busy got %b want 0", busy); else pass++;
  endtask

  task automatic test_directed;
    check_op8("basic_5_3", 8'h05, 8'h03, 1'b0);
    check_op8("underflow_0_1", 8'h00, 8'h01, 1'b0);
    check_op8("bin_80_7f", 8'h80, 8'h7F, 1'b1);
    check_op8("max_ff_00", 8'hFF, 8'h00, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      check_op8("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_sweep_w2;
    int nerr, ntmo, cyc;
    nerr = 0; ntmo = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      a2 = 2'(k >> 3); b2 = 2'(k >> 1); bin2 = 1'(k);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0; cyc = 0;
      while (!done2 && cyc < 20) begin @(negedge clk); cyc++; end
      if (!done2) ntmo++;
      else if (diff2 !== 2'(ref_diff(2, k >> 3, (k >> 1) & 3, k & 1)) ||
               bout2 !== ref_bout(k >> 3, (k >> 1) & 3, k & 1)) begin
        nerr++;
        $display("FAIL sweep_w2 a=%0d b=%0d bin=%0d got %0d/%b", k >> 3, (k >> 1) & 3, k & 1, diff2, bout2);
      end
    end
    total++;
    if (nerr !== 0 || ntmo !== 0) $display("FAIL sweep_w2 errors got %0d timeouts %0d want 0", nerr, ntmo); else pass++;
  endtask

  task automatic test_ignore_start;
    int ndone, nbusy;
    @(negedge clk);
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ndone = 0; nbusy = 0;
    for (int c = 0; c < 30; c++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        total++;
        if (diff !== 8'h0F || bout !== 1'b0) $display("FAIL ignore_start result got %h/%b want 0f/0", diff, bout); else pass++;
      end
      start = (c == 2 || c == 5 || c == 8);
      if (c == 2) begin a = 8'h33; b = 8'h44; bin = 1'b1; end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (ndone !== 1) $display("FAIL ignore_start done count got %0d want 1", ndone); else pass++;
    total++;
    if (nbusy !== 8) $display("FAIL ignore_start busy cycles got %0d want 8", nbusy); else pass++;
  endtask

  task automatic test_reset_mid;
    int nb, nd, cyc;
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; nb = 0; cyc = 0;
    while (nb < 4 && cyc < 20) begin
      if (busy) nb++;
      if (nb < 4) @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0)
      $display("FAIL reset_mid state got busy=%b done=%b diff=%h bout=%b want 0/0/00/0", busy, done, diff, bout);
    else pass++;
    nd = 0;
    for (int c = 0; c < 15; c++) begin if (done || busy) nd++; @(negedge clk); end
    total++;
    if (nd !== 0) $display("FAIL reset_mid activity after reset got %0d want 0", nd); else pass++;
    check_op8("after_reset_9_4", 8'h09, 8'h04, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] ca, cb;
    logic       cbin;
    int cyc, last, ndone, nerr, ngap;
    @(negedge clk);
    ca = 8'($urandom_range(0, 255)); cb = 8'($urandom_range(0, 255)); cbin = 1'($urandom_range(0, 1));
    a = ca; b = cb; bin = cbin; start = 1'b1;
    cyc = 0; last = -1; ndone = 0; nerr = 0; ngap = 0;
    while (ndone < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (last >= 0 && cyc - last !== 10) begin
          ngap++;
          $display("FAIL back_to_back spacing got %0d want 10", cyc - last);
        end
        if (diff !== 8'(ref_diff(8, ca, cb, cbin)) || bout !== ref_bout(ca, cb, cbin)) begin
          nerr++;
          $display("FAIL back_to_back result got %h/%b want %h/%b", diff, bout,
                   8'(ref_diff(8, ca, cb, cbin)), ref_bout(ca, cb, cbin));
        end
        last = cyc; ndone++;
        // Next capture happens two edges from now, in IDLE
        ca = 8'($urandom_range(0, 255)); cb = 8'($urandom_range(0, 255)); cbin = 1'($urandom_range(0, 1));
        a = ca; b = cb; bin = cbin;
      end
    end
    start = 1'b0;
    total++;
    if (ndone !== 6) $display("FAIL back_to_back done count got %0d want 6", ndone); else pass++;
    total++;
    if (ngap !== 0 || nerr !== 0) $display("FAIL back_to_back gap errors %0d result errors %0d want 0", ngap, nerr); else pass++;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_sweep_w2;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
